// File: rtl/load_store_unit_if.sv
// Request/response and data-memory bus bundle for load_store_unit.
// slave = the unit itself; master = execute stage plus data memory.
interface load_store_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic        req_byte;
    logic        req_signed;
    logic [15:0] req_addr;
    logic [15:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_rdata;
    logic        rsp_err;
    logic        MemRead;
    logic        MemWrite;
    logic [15:0] Address;
    logic [15:0] WriteData;
    logic [15:0] ReadData;

    modport master (
        output req_valid, req_write, req_byte, req_signed, req_addr, req_wdata, rsp_ready, ReadData,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, MemRead, MemWrite, Address, WriteData
    );

    modport slave (
        input  req_valid, req_write, req_byte, req_signed, req_addr, req_wdata, rsp_ready, ReadData,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, MemRead, MemWrite, Address, WriteData
    );
endinterface

// File: rtl/load_store_unit.sv
// Single-request load/store initiator for a 16-bit byte-addressed data memory.
// Optional ALIGN_CHECK_EN: reject halfword accesses at odd addresses.
module load_store_unit #(
    parameter int unsigned ADDR_LIMIT  = 64,
    parameter int unsigned WAIT_STATES = 0
) (
    input logic              clk,
    input logic              reset,
    load_store_unit_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

    localparam logic [2:0]  WS    = 3'(WAIT_STATES);
    localparam logic [16:0] LIMIT = 17'(ADDR_LIMIT);

    state_t      state;
    logic [2:0]  cnt;
    logic        wr_q;
    logic        byte_q;
    logic        sgn_q;
    logic [7:0]  wdata_q;
    logic [16:0] addr_end;
    logic        acc_err;

    // 17-bit sum so that 0xFFFF does not wrap into range
    always_comb begin
        addr_end = {1'b0, bus.req_addr} + 17'd1;
        acc_err  = (addr_end >= LIMIT);
`ifdef ALIGN_CHECK_EN
        if (!bus.req_byte && bus.req_addr[0])
            acc_err = 1'b1;
`endif
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state         <= IDLE;
            cnt           <= '0;
            wr_q          <= 1'b0;
            byte_q        <= 1'b0;
            sgn_q         <= 1'b0;
            wdata_q       <= '0;
            bus.req_ready <= 1'b1;
            bus.rsp_valid <= 1'b0;
            bus.rsp_rdata <= '0;
            bus.rsp_err   <= 1'b0;
            bus.MemRead   <= 1'b0;
            bus.MemWrite  <= 1'b0;
            bus.Address   <= '0;
            bus.WriteData <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        wr_q          <= bus.req_write;
                        byte_q        <= bus.req_byte;
                        sgn_q         <= bus.req_signed;
                        wdata_q       <= bus.req_wdata[7:0];
                        bus.req_ready <= 1'b0;
                        cnt           <= WS;
                        if (acc_err) begin
                            state         <= RESP;
                            bus.rsp_valid <= 1'b1;
                            bus.rsp_err   <= 1'b1;
                            bus.rsp_rdata <= '0;
                        end else if (bus.req_write && !bus.req_byte) begin
                            state         <= WR;
                            bus.MemWrite  <= 1'b1;
                            bus.Address   <= bus.req_addr;
                            bus.WriteData <= bus.req_wdata;
                        end else begin
                            state       <= RD;
                            bus.MemRead <= 1'b1;
                            bus.Address <= bus.req_addr;
                        end
                    end
                end
                RD: begin
                    if (cnt != 3'd0) begin
                        cnt <= cnt - 3'd1;
                    end else begin
                        bus.MemRead <= 1'b0;
                        if (wr_q) begin
                            // byte store: keep the neighbouring byte, replace byte A
                            state         <= WR;
                            cnt           <= WS;
                            bus.MemWrite  <= 1'b1;
                            bus.WriteData <= {bus.ReadData[15:8], wdata_q};
                        end else begin
                            state         <= RESP;
                            bus.rsp_valid <= 1'b1;
                            bus.rsp_err   <= 1'b0;
                            if (!byte_q)
                                bus.rsp_rdata <= bus.ReadData;
                            else if (sgn_q)
                                bus.rsp_rdata <= {{8{bus.ReadData[7]}}, bus.ReadData[7:0]};
                            else
                                bus.rsp_rdata <= {8'h00, bus.ReadData[7:0]};
                        end
                    end
                end
                WR: begin
                    if (cnt != 3'd0) begin
                        cnt <= cnt - 3'd1;
                    end else begin
                        state         <= RESP;
                        bus.MemWrite  <= 1'b0;
                        bus.rsp_valid <= 1'b1;
                        bus.rsp_rdata <= '0;
                        bus.rsp_err   <= 1'b0;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        state         <= IDLE;
                        bus.rsp_valid <= 1'b0;
                        bus.req_ready <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: one unit with no wait states, one with two.
module tb_load_store_unit;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    load_store_unit_if bus0();
    load_store_unit_if bus1();

    load_store_unit #(.ADDR_LIMIT(64), .WAIT_STATES(0)) dut0 (.clk(clk), .reset(reset), .bus(bus0));
    load_store_unit #(.ADDR_LIMIT(64), .WAIT_STATES(2)) dut1 (.clk(clk), .reset(reset), .bus(bus1));

    logic [7:0]  mem0 [0:255];
    logic [7:0]  mem1 [0:255];
    int          rd0 = 0, wr0 = 0, both0 = 0, rd1 = 0;
    logic [15:0] last_wd = '0;

    always_comb begin
        bus0.ReadData = bus0.MemRead ? {mem0[bus0.Address[7:0] + 8'd1], mem0[bus0.Address[7:0]]} : 16'h0000;
        bus1.ReadData = bus1.MemRead ? {mem1[bus1.Address[7:0] + 8'd1], mem1[bus1.Address[7:0]]} : 16'h0000;
    end

    // memory commits writes on the falling edge; also tallies enable cycles
    always @(negedge clk) begin
        if (bus0.MemRead) rd0++;
        if (bus0.MemRead && bus0.MemWrite) both0++;
        if (bus0.MemWrite) begin
            wr0++;
            last_wd = bus0.WriteData;
            mem0[bus0.Address[7:0]]        = bus0.WriteData[7:0];
            mem0[bus0.Address[7:0] + 8'd1] = bus0.WriteData[15:8];
        end
        if (bus1.MemRead) rd1++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic req0(input logic w, input logic b, input logic s, input logic [15:0] a,
                        input logic [15:0] d, output logic [15:0] rdata, output logic err,
                        output int lat);
        int n;
        @(negedge clk);
        rd0 = 0;
        wr0 = 0;
        bus0.req_write  = w;
        bus0.req_byte   = b;
        bus0.req_signed = s;
        bus0.req_addr   = a;
        bus0.req_wdata  = d;
        bus0.req_valid  = 1'b1;
        bus0.rsp_ready  = 1'b1;
        n = 0;
        while (bus0.req_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) chk("accept_timeout", 32'(n), 32'd0);
        @(posedge clk);
        #1;
        bus0.req_valid = 1'b0;
        lat = 1;
        while (bus0.rsp_valid !== 1'b1 && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        rdata = bus0.rsp_rdata;
        err   = bus0.rsp_err;
    endtask

    logic [15:0] rdata;
    logic        err;
    int          lat;

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem0[i] = 8'h00;
            mem1[i] = 8'h00;
        end
        mem0[8'h20] = 8'h34; mem0[8'h21] = 8'h12;
        mem0[8'h3E] = 8'hC3; mem0[8'h3F] = 8'h5A;
        mem0[8'h12] = 8'h77;
        mem1[8'h08] = 8'h11; mem1[8'h09] = 8'h22;
        mem1[8'h0A] = 8'h44; mem1[8'h0B] = 8'h33;
        {bus0.req_valid, bus0.req_write, bus0.req_byte, bus0.req_signed} = 4'b0000;
        {bus1.req_valid, bus1.req_write, bus1.req_byte, bus1.req_signed} = 4'b0000;
        bus0.req_addr = '0; bus0.req_wdata = '0; bus0.rsp_ready = 1'b1;
        bus1.req_addr = '0; bus1.req_wdata = '0; bus1.rsp_ready = 1'b1;

        @(posedge clk); #1;
        chk("rst_req_ready", 32'(bus0.req_ready), 32'd1);
        chk("rst_rsp_valid", 32'(bus0.rsp_valid), 32'd0);
        chk("rst_rsp_rdata", 32'(bus0.rsp_rdata), 32'd0);
        chk("rst_rsp_err", 32'(bus0.rsp_err), 32'd0);
        chk("rst_memread", 32'(bus0.MemRead), 32'd0);
        chk("rst_memwrite", 32'(bus0.MemWrite), 32'd0);
        chk("rst_address", 32'(bus0.Address), 32'd0);
        chk("rst_writedata", 32'(bus0.WriteData), 32'd0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;

        req0(1'b1, 1'b0, 1'b0, 16'h0010, 16'hBEEF, rdata, err, lat);
        chk("sth_err", 32'(err), 32'd0);
        chk("sth_rdata", 32'(rdata), 32'd0);
        chk("sth_lat", 32'(lat), 32'd2);
        chk("sth_mem", 32'({mem0[8'h11], mem0[8'h10]}), 32'hBEEF);
        chk("sth_reads", 32'(rd0), 32'd0);
        chk("sth_writes", 32'(wr0), 32'd1);

        req0(1'b0, 1'b0, 1'b0, 16'h0010, 16'h0000, rdata, err, lat);
        chk("ldh_rdata", 32'(rdata), 32'hBEEF);
        chk("ldh_err", 32'(err), 32'd0);
        chk("ldh_lat", 32'(lat), 32'd2);

        req0(1'b1, 1'b1, 1'b0, 16'h0020, 16'h99A5, rdata, err, lat);
        chk("stb_lat", 32'(lat), 32'd3);
        chk("stb_reads", 32'(rd0), 32'd1);
        chk("stb_writes", 32'(wr0), 32'd1);
        chk("stb_wdata", 32'(last_wd), 32'h12A5);
        chk("stb_mem", 32'({mem0[8'h21], mem0[8'h20]}), 32'h12A5);

        req0(1'b0, 1'b1, 1'b1, 16'h0020, 16'h0000, rdata, err, lat);
        chk("ldb_signed", 32'(rdata), 32'hFFA5);
        req0(1'b0, 1'b1, 1'b0, 16'h0020, 16'h0000, rdata, err, lat);
        chk("ldb_unsigned", 32'(rdata), 32'h00A5);
        chk("ldb_lat", 32'(lat), 32'd2);

        req0(1'b0, 1'b0, 1'b0, 16'h003F, 16'h0000, rdata, err, lat);
        chk("lim_err", 32'(err), 32'd1);
        chk("lim_rdata", 32'(rdata), 32'd0);
        chk("lim_reads", 32'(rd0), 32'd0);
        chk("lim_lat", 32'(lat), 32'd1);

        req0(1'b0, 1'b0, 1'b0, 16'h003E, 16'h0000, rdata, err, lat);
        chk("edge_err", 32'(err), 32'd0);
        chk("edge_rdata", 32'(rdata), 32'h5AC3);

        req0(1'b0, 1'b0, 1'b0, 16'hFFFF, 16'h0000, rdata, err, lat);
        chk("ffff_err", 32'(err), 32'd1);

        req0(1'b1, 1'b0, 1'b0, 16'h003F, 16'h1111, rdata, err, lat);
        chk("stlim_err", 32'(err), 32'd1);
        chk("stlim_writes", 32'(wr0), 32'd0);

        req0(1'b0, 1'b0, 1'b0, 16'h0011, 16'h0000, rdata, err, lat);
`ifdef ALIGN_CHECK_EN
        chk("odd_err", 32'(err), 32'd1);
        chk("odd_rdata", 32'(rdata), 32'd0);
        chk("odd_reads", 32'(rd0), 32'd0);
`else
        chk("odd_err", 32'(err), 32'd0);
        chk("odd_rdata", 32'(rdata), 32'h77BE);
        chk("odd_reads", 32'(rd0), 32'd1);
`endif
        chk("never_both", 32'(both0), 32'd0);

        // wait-state unit: slow load, stalled response, queued second request
        @(negedge clk);
        rd1 = 0;
        bus1.rsp_ready = 1'b0;
        bus1.req_addr  = 16'h0008;
        bus1.req_valid = 1'b1;
        @(posedge clk); #1;
        bus1.req_addr = 16'h000A;
        lat = 1;
        while (bus1.rsp_valid !== 1'b1 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("ws_lat", 32'(lat), 32'd4);
        chk("ws_reads", 32'(rd1), 32'd3);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("ws_hold_valid", 32'(bus1.rsp_valid), 32'd1);
            chk("ws_hold_rdata", 32'(bus1.rsp_rdata), 32'h2211);
            chk("ws_hold_ready", 32'(bus1.req_ready), 32'd0);
        end
        bus1.rsp_ready = 1'b1;
        @(posedge clk); #1;
        chk("ws_idle_ready", 32'(bus1.req_ready), 32'd1);
        chk("ws_idle_valid", 32'(bus1.rsp_valid), 32'd0);
        @(posedge clk); #1;
        bus1.req_valid = 1'b0;
        chk("ws_2nd_ready", 32'(bus1.req_ready), 32'd0);
        chk("ws_2nd_memread", 32'(bus1.MemRead), 32'd1);
        lat = 1;
        while (bus1.rsp_valid !== 1'b1 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("ws_2nd_rdata", 32'(bus1.rsp_rdata), 32'h3344);

        // reset while a halfword store sits in WR
        @(negedge clk);
        bus0.req_write = 1'b1; bus0.req_byte = 1'b0;
        bus0.req_addr = 16'h0030; bus0.req_wdata = 16'h1234;
        bus0.req_valid = 1'b1;
        @(posedge clk); #1;
        bus0.req_valid = 1'b0;
        chk("mid_memwrite", 32'(bus0.MemWrite), 32'd1);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        chk("mid_drop", 32'(bus0.MemWrite), 32'd0);
        @(posedge clk); #1;
        chk("mid_req_ready", 32'(bus0.req_ready), 32'd1);
        chk("mid_rsp_valid", 32'(bus0.rsp_valid), 32'd0);
        chk("mid_rsp_rdata", 32'(bus0.rsp_rdata), 32'd0);
        chk("mid_rsp_err", 32'(bus0.rsp_err), 32'd0);
        chk("mid_memread", 32'(bus0.MemRead), 32'd0);
        chk("mid_address", 32'(bus0.Address), 32'd0);
        chk("mid_writedata", 32'(bus0.WriteData), 32'd0);
        @(negedge clk);
        reset = 1'b1;

        req0(1'b0, 1'b0, 1'b0, 16'h0010, 16'h0000, rdata, err, lat);
        chk("post_rst_load", 32'(rdata), 32'hBEEF);
        chk("post_rst_lat", 32'(lat), 32'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
